// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART TX byte path among N requesters.
// Define UART_ARB_HDR_EN to emit a {HDR_TAG, owner} header byte before each granted packet.
module uart_tx_arbiter #(
  parameter int         N       = 4,
  parameter int         TIMEOUT = 1024,
  parameter int         GW      = 8,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_valid_i,
  input  logic [N*8-1:0]  req_data_i,
  input  logic [N-1:0]    req_last_i,
  output logic [N-1:0]    req_ready_o,
  output logic            tx_valid_o,
  output logic [7:0]      tx_data_o,
  input  logic            tx_ready_i,
  input  logic [GW-1:0]   gap_i,
  output logic [N-1:0]    grant_o,
  output logic            busy_o,
  output logic            timeout_o
);

  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] PTR_INIT = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
`ifdef UART_ARB_HDR_EN
    S_GAP  = 2'd2,
    S_HDR  = 2'd3
`else
    S_GAP  = 2'd2
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            timeout_q, timeout_d;

  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            owner_valid;
  logic            owner_last;
  logic [7:0]      owner_data;
  logic            wd_fire;

  // Search starts just after the previous owner, so it gets lowest priority.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last_q) + i) % N);
      if (!pick_any && req_valid_i[cand]) begin
        pick_any = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign owner_valid = req_valid_i[owner_q];
  assign owner_last  = req_last_i[owner_q];
  assign owner_data  = req_data_i[{owner_q, 3'b000} +: 8];

  // Only fires with valid low, so a same-cycle last byte always takes precedence.
  assign wd_fire = (TIMEOUT != 0) && !owner_valid && (wd_q == WD_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      last_q    <= PTR_INIT;
      grant_q   <= '0;
      wd_q      <= '0;
      gap_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    grant_d    = grant_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    timeout_d  = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          wd_d              = '0;
`ifdef UART_ARB_HDR_EN
          state_d           = S_HDR;
`else
          state_d           = S_SEND;
`endif
        end
      end

`ifdef UART_ARB_HDR_EN
      S_HDR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = {HDR_TAG, 4'(owner_q)};
        if (tx_ready_i) begin
          wd_d    = '0;
          state_d = S_SEND;
        end
      end
`endif

      S_SEND: begin
        tx_valid_o = owner_valid;
        if (owner_valid) begin
          tx_data_o = owner_data;
        end

        if (owner_valid) begin
          wd_d = '0;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + WW'(1);
        end

        if ((owner_valid && tx_ready_i && owner_last) || wd_fire) begin
          timeout_d = wd_fire;
          last_d    = owner_q;
          grant_d   = '0;
          if (gap_i != '0) begin
            gap_d   = gap_i;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ready
      assign req_ready_o[gi] = (state_q == S_SEND) && grant_q[gi] && tx_ready_i;
    end
  endgenerate

`ifndef UART_ARB_HDR_EN
  logic unused_hdr_tag;
  assign unused_hdr_tag = ^HDR_TAG;
`endif

  assign grant_o   = grant_q;
  assign busy_o    = (state_q != S_IDLE);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (default build, N=4, TIMEOUT=16) with a
// byte/grant scoreboard filled as stimulus is queued and drained by a negedge monitor.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i;
  logic [N*8-1:0]  req_data_i;
  logic [N-1:0]    req_last_i;
  logic [N-1:0]    req_ready_o;
  logic            tx_valid_o;
  logic [7:0]      tx_data_o;
  logic            tx_ready_i;
  logic [7:0]      gap_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;
  logic            timeout_o;

  uart_tx_arbiter #(.N(N), .TIMEOUT(16), .GW(8), .HDR_TAG(4'hA)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .gap_i       (gap_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  logic [8:0]  src_mem [N][32];
  int          src_cnt [N];
  int          src_ptr [N];
  int          exp_grant [$];
  logic [15:0] exp_byte [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, gapc = 0, tmo_cnt = 0, tmo_cyc = 0;
  int onset_cyc = -1, onset_gapc = 0, xfer_cnt = 0, xfer_cyc = 0;
  bit rr_chk = 1'b0;
  logic [N-1:0] prev_grant = '0, hs = '0, s_grant = '0, s_rdy = '0;
  logic         s_txv = 1'b0, s_busy = 1'b0;
  logic [7:0]   s_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < N; k++) begin
      src_cnt[k] = 0;
      src_ptr[k] = 0;
    end
  endtask

  task automatic add_byte(input int k, input logic [7:0] d, input logic l);
    src_mem[k][src_cnt[k]] = {l, d};
    src_cnt[k]++;
  endtask

  task automatic exp_b(input int k, input logic [7:0] d);
    exp_byte.push_back({8'(k), d});
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (src_ptr[k] < src_cnt[k]) begin
        req_valid_i[k]        = 1'b1;
        req_data_i[8*k +: 8]  = src_mem[k][src_ptr[k]][7:0];
        req_last_i[k]         = src_mem[k][src_ptr[k]][8];
      end else begin
        req_valid_i[k]        = 1'b0;
        req_data_i[8*k +: 8]  = 8'h00;
        req_last_i[k]         = 1'b0;
      end
    end
  endtask

  task automatic mon();
    int          e;
    logic [15:0] ent;
    @(negedge clk);
    cyc++;
    s_grant = grant_o;
    s_txv   = tx_valid_o;
    s_data  = tx_data_o;
    s_busy  = busy_o;
    s_rdy   = req_ready_o;
    hs      = req_valid_i & req_ready_o;
    if (busy_o && !tx_valid_o && grant_o == '0) gapc++;
    if (timeout_o) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
    chk("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
    if (grant_o != '0 && prev_grant == '0) begin
      if (exp_grant.size() == 0) begin
        chk("grant_unexpected", 32'(grant_o), 32'd0);
      end else begin
        e = exp_grant.pop_front();
        chk("grant_owner", 32'(grant_o), 32'(1 << e));
      end
      if (rr_chk && onset_cyc >= 0) chk("rr_period", 32'(cyc - onset_cyc), 32'd2);
      onset_cyc  = cyc;
      onset_gapc = gapc;
    end
    prev_grant = grant_o;
    if (tx_valid_o && tx_ready_i) begin
      xfer_cnt++;
      xfer_cyc = cyc;
      $display("xfer cyc=%0d grant=%b data=%02h", cyc, grant_o, tx_data_o);
      if (exp_byte.size() == 0) begin
        chk("xfer_unexpected", 32'(tx_data_o), 32'hFFFF_FFFF);
      end else begin
        ent = exp_byte.pop_front();
        chk("tx_data", 32'(tx_data_o), 32'(ent[7:0]));
        chk("tx_owner", 32'(grant_o), 32'(1 << ent[15:8]));
        chk("ready_mirror", 32'(req_ready_o), 32'(grant_o));
      end
    end
  endtask

  task automatic cycle();
    mon();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (hs[k]) src_ptr[k]++;
    drive();
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((exp_byte.size() != 0 || exp_grant.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_byte.size() + exp_grant.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    clear_src();
    drive();
    cycle();
    cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    int x0, g0, n;
    int pat [4] = '{1, 0, 0, 1};
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    req_last_i  = '0;
    tx_ready_i  = 1'b1;
    gap_i       = 8'd0;
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_txv", 32'(tx_valid_o), 32'd0);
    chk("rst_data", 32'(tx_data_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    rst_i = 1'b0;
    drive();
    cycle();
    cycle();

    // Single 3-byte packet from requester 1.
    exp_grant.push_back(1);
    add_byte(1, 8'h11, 1'b0); exp_b(1, 8'h11);
    add_byte(1, 8'h22, 1'b0); exp_b(1, 8'h22);
    add_byte(1, 8'h33, 1'b1); exp_b(1, 8'h33);
    drive();
    cycle();
    chk("s1_idle_grant", 32'(s_grant), 32'd0);
    chk("s1_idle_txv", 32'(s_txv), 32'd0);
    cycle();
    chk("s1_grant", 32'(s_grant), 32'b0010);
    chk("s1_b0", 32'(s_data), 32'h11);
    cycle();
    chk("s1_b1", 32'(s_data), 32'h22);
    cycle();
    chk("s1_b2", 32'(s_data), 32'h33);
    cycle();
    chk("s1_idle_busy", 32'(s_busy), 32'd0);
    chk("s1_idle_grant2", 32'(s_grant), 32'd0);

    // Round-robin with all requesters continuously valid.
    pulse_reset();
    rr_chk    = 1'b1;
    onset_cyc = -1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        exp_grant.push_back(k);
        add_byte(k, 8'(8'h40 + 16 * k + r), 1'b1);
        exp_b(k, 8'(8'h40 + 16 * k + r));
      end
    end
    drive();
    drain(40, "rr");
    rr_chk = 1'b0;

    // Backpressure on a 2-byte packet.
    clear_src();
    x0 = xfer_cnt;
    exp_grant.push_back(3);
    add_byte(3, 8'hA1, 1'b0); exp_b(3, 8'hA1);
    add_byte(3, 8'hA2, 1'b1); exp_b(3, 8'hA2);
    drive();
    cycle();
    for (int i = 0; i < 4; i++) begin
      tx_ready_i = pat[i][0];
      cycle();
      chk("bp_ready", 32'(s_rdy), (pat[i] != 0) ? 32'b1000 : 32'd0);
      chk("bp_txv", 32'(s_txv), 32'd1);
      chk("bp_data", 32'(s_data), (i == 0) ? 32'hA1 : 32'hA2);
    end
    tx_ready_i = 1'b1;
    repeat (3) cycle();
    chk("bp_xfers", 32'(xfer_cnt - x0), 32'd2);
    chk("bp_drain", 32'(exp_byte.size()), 32'd0);

    // Inter-packet gap of 5 cycles; gap_i changed mid-gap must be ignored.
    clear_src();
    gap_i = 8'd5;
    gapc  = 0;
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    add_byte(0, 8'hC0, 1'b1); exp_b(0, 8'hC0);
    add_byte(1, 8'hC1, 1'b1); exp_b(1, 8'hC1);
    drive();
    drain(40, "gap");
    chk("gap_len", 32'(onset_gapc), 32'd5);
    g0    = gapc;
    gap_i = 8'd0;
    repeat (8) cycle();
    chk("gap_sampled", 32'(gapc - g0), 32'd5);
    chk("gap_idle", 32'(s_busy), 32'd0);

    // Watchdog: requester 2 sends one non-last byte then goes quiet.
    clear_src();
    tmo_cnt = 0;
    exp_grant.push_back(2);
    add_byte(2, 8'h5A, 1'b0); exp_b(2, 8'h5A);
    drive();
    cycle();
    cycle();
    n = 0;
    while (tmo_cnt == 0 && n < 40) begin
      cycle();
      n++;
    end
    chk("wd_fired", 32'(tmo_cnt), 32'd1);
    chk("wd_delay", 32'(tmo_cyc - xfer_cyc), 32'd17);
    repeat (3) cycle();
    chk("wd_pulse_once", 32'(tmo_cnt), 32'd1);
    chk("wd_grant_clear", 32'(s_grant), 32'd0);
    chk("wd_idle", 32'(s_busy), 32'd0);
    clear_src();
    for (int j = 0; j < N; j++) begin
      exp_grant.push_back((3 + j) % N);
      exp_b((3 + j) % N, 8'(8'hD0 + (3 + j) % N));
    end
    for (int k = 0; k < N; k++) add_byte(k, 8'(8'hD0 + k), 1'b1);
    drive();
    drain(30, "wd_rr");

    // Asynchronous reset in the middle of a packet.
    clear_src();
    exp_grant.push_back(1);
    add_byte(1, 8'hE0, 1'b0); exp_b(1, 8'hE0);
    add_byte(1, 8'hE1, 1'b0); exp_b(1, 8'hE1);
    add_byte(1, 8'hE2, 1'b1); exp_b(1, 8'hE2);
    drive();
    cycle();
    cycle();
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_grant", 32'(grant_o), 32'd0);
    chk("arst_txv", 32'(tx_valid_o), 32'd0);
    chk("arst_ready", 32'(req_ready_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    exp_byte.delete();
    exp_grant.delete();
    clear_src();
    drive();
    cycle();
    cycle();
    rst_i = 1'b0;
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    add_byte(1, 8'hF1, 1'b1);
    add_byte(0, 8'hF0, 1'b1);
    exp_b(0, 8'hF0);
    exp_b(1, 8'hF1);
    drive();
    drain(20, "arst");
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single UART transmit byte path (TX FIFO write port / uart_tx byte input) among N requesters.
- Each requester presents a valid/ready byte stream with an end-of-packet marker. Once granted, a requester owns the port until its last byte, a timeout, or reset.
- Sits between the firmware/DMA byte sources and the uart_core TX path. Adds a programmable inter-packet idle gap.

Parameters:
- N, 4, number of requesters (2..16).
- TIMEOUT, 1024, SEND-state cycles allowed with granted req_valid low before forced release; 0 disables the watchdog.
- GW, 8, width of the gap_i count.
- HDR_TAG, 4'hA, upper nibble of the optional header byte.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  N  per-requester byte valid
- req_data_i  in  N*8  per-requester byte; requester k uses bits [8k+7:8k]
- req_last_i  in  N  byte is last of packet
- req_ready_o  out  N  byte accepted from requester k
- tx_valid_o  out  1  byte valid toward UART TX
- tx_data_o  out  8  byte toward UART TX
- tx_ready_i  in  1  UART TX accepts byte
- gap_i  in  GW  idle cycles inserted after each packet
- grant_o  out  N  one-hot current owner; 0 when no owner
- busy_o  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async, rst_i=1):
  - State = IDLE. grant_o=0, req_ready_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, timeout_o=0.
  - Round-robin pointer last_q = N-1, so requester 0 wins first. Counters = 0.
  - Reset mid-packet aborts the packet silently; no partial state survives.
- States: IDLE, SEND, GAP (HDR added by the optional feature).
- IDLE:
  - If any req_valid_i is set, pick the first set bit searching last_q+1, last_q+2, ... mod N. Register the grant and go to SEND.
  - Latency: req_valid_i high in cycle t gives grant_o and tx_valid_o in cycle t+1. No transfer occurs in IDLE.
- SEND with owner g:
  - tx_valid_o = req_valid_i[g]; tx_data_o = req_data_i[g] when valid, else 0.
  - req_ready_o[g] = tx_ready_i; all other ready bits are 0. This path is combinational; it adds no bubble and supports one byte per cycle.
  - Transfer = tx_valid_o & tx_ready_i.
  - Transfer with req_last_i[g]=1: last_q <= g, grant_o <= 0. Go to GAP if gap_i != 0, else IDLE.
  - Watchdog counter:
    - Clears on every cycle where req_valid_i[g]=1, and on entry to SEND.
    - Increments on each cycle where req_valid_i[g]=0.
    - When TIMEOUT != 0 and the count reaches TIMEOUT-1 with valid still low, the next edge pulses timeout_o for one cycle. It also sets last_q <= g and grant_o <= 0, and takes the same GAP/IDLE exit as a normal last byte.
  - Valid and last arriving in the same cycle as the timeout edge: the transfer wins and timeout_o stays 0.
- GAP:
  - gap_i is sampled into an down-counter on the exit edge from SEND. Changes to gap_i during GAP are ignored.
  - The counter decrements each cycle. The block returns to IDLE on the edge where the counter equals 1.
  - Result: exactly gap_i cycles with busy_o=1 and tx_valid_o=0.
  - Requests are held off during GAP; arbitration resumes in IDLE.
- Fairness:
  - The requester that just finished has lowest priority in the next arbitration.
  - With all N requesters continuously valid, grants rotate 0,1,...,N-1,0.
- Requester k dropping valid while not granted has no effect.
- grant_o is always one-hot or zero. busy_o is a direct decode of the state.

Optional Feature:
- Macro: UART_ARB_HDR_EN.
- When defined:
  - IDLE goes to HDR instead of SEND.
  - In HDR: tx_valid_o=1, tx_data_o={HDR_TAG, g[3:0]}, req_ready_o=0, grant_o already shows the owner.
  - On tx_ready_i=1, HDR goes to SEND.
  - The watchdog does not run in HDR.
  - Reset during HDR returns to IDLE with no header byte counted.
- When undefined:
  - The HDR state and its logic are absent; IDLE goes directly to SEND.
  - No header byte is ever emitted.

Test Plan:
- Reset then single packet:
  - Stimulus: req 1 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), tx_ready_i=1, gap_i=0.
  - Required: grant_o=4'b0010 one cycle after valid; tx_data_o sequence 11,22,33 on consecutive cycles; IDLE on the cycle after 0x33.
- Round-robin:
  - Stimulus: all 4 requesters continuously valid with 1-byte packets, gap_i=0.
  - Required: grant order 0,1,2,3,0,1; each 1-byte grant occupies 2 cycles (IDLE+SEND).
- Backpressure:
  - Stimulus: tx_ready_i toggles 1,0,0,1 during a 2-byte packet.
  - Required: req_ready_o[g] mirrors tx_ready_i; tx_data_o holds stable while ready=0; exactly 2 transfers.
- Gap:
  - Stimulus: gap_i=5, two requesters valid.
  - Required: exactly 5 cycles of busy_o=1 and tx_valid_o=0 between the first packet's last byte and the next grant.
- Watchdog:
  - Stimulus: TIMEOUT=16; req 2 sends 1 non-last byte, then drops valid.
  - Required: timeout_o pulses once, 16 cycles after valid fell; grant_o=0 afterwards; next arbitration starts from requester 3.
- Async reset mid-packet:
  - Stimulus: assert rst_i during SEND between edges.
  - Required: grant_o, tx_valid_o and req_ready_o go to 0 immediately; after release, requester 0 wins first.
  - If UART_ARB_HDR_EN is defined: the next grant emits 0xA0 before data.
